// File: rtl/nibble_serial_subtractor_if.sv
// rtl/nibble_serial_subtractor_if.sv - start/done handshake bundle for the nibble-serial subtractor
interface nibble_serial_subtractor_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero, ovf
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - multi-cycle a - b - bin, one 4-bit borrow-lookahead slice per clock
module nibble_serial_subtractor #(
    parameter int W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    nibble_serial_subtractor_if.slave  bus
);
    localparam int N  = W / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          a_msb_q;
    logic          b_msb_q;
    logic          borrow_q;
    logic [KW-1:0] k_q;
    logic [W-1:0]  res_q;
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  diff_q;
    logic          bout_q;
    logic          zero_q;
    logic          ovf_q;

    logic [3:0]    a_s;
    logic [3:0]    b_s;
    logic [3:0]    g;
    logic [3:0]    p;
    logic          c1, c2, c3, c4;
    logic [3:0]    d_s;
    logic [W-1:0]  res_d;

    // Operands shift right each RUN cycle, so the active slice is always bits 3..0.
    always_comb begin
        a_s = a_q[3:0];
        b_s = b_q[3:0];
        g   = ~a_s & b_s;
        p   = ~(a_s ^ b_s);
        c1  = g[0] | (p[0] & borrow_q);
        c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_q);
        c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & borrow_q);
        c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & borrow_q);
        d_s   = a_s ^ b_s ^ {c3, c2, c1, borrow_q};
        res_d = (res_q >> 4) | (W'(d_s) << (W - 4));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            borrow_q <= 1'b0;
            k_q      <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        a_msb_q  <= bus.a[W-1];
                        b_msb_q  <= bus.b[W-1];
                        borrow_q <= bus.bin;
                        k_q      <= '0;
                        res_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 4;
                    b_q      <= b_q >> 4;
                    borrow_q <= c4;
                    res_q    <= res_d;
                    // Visible outputs only change here, so RUN never exposes a partial difference.
                    if (k_q == KW'(N - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        bout_q  <= c4;
                        zero_q  <= (res_d == '0);
                        ovf_q   <= (a_msb_q != b_msb_q) && (res_d[W-1] != a_msb_q);
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - table-driven and sequence checks for nibble_serial_subtractor (W=8)
module tb_nibble_serial_subtractor;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    nibble_serial_subtractor_if #(.W(8)) bus ();

    nibble_serial_subtractor #(.W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       zero;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, 32'(cyc), 32'd2);
    endtask

    task automatic check_result(input string name, input vec_t v);
        check({name, "_done"}, 32'(bus.done), 32'd1);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_diff"}, 32'(bus.diff), 32'(v.diff));
        check({name, "_bout"}, 32'(bus.bout), 32'(v.bout));
        check({name, "_zero"}, 32'(bus.zero), 32'(v.zero));
        check({name, "_ovf"},  32'(bus.ovf),  32'(v.ovf));
    endtask

    initial begin
        logic [7:0] prev_diff;
        int         cyc;
        int         pulses;
        vec_t       v;

        checks = 0;
        errors = 0;
        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h10, 8'h0F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.bin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_ovf",  32'(bus.ovf),  32'd0);
        reset     = 1'b0;
        prev_diff = 8'h00;

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            @(negedge clk);
            bus.start = 1'b1;
            bus.a     = v.a;
            bus.b     = v.b;
            bus.bin   = v.bin;
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = ~v.a;
            bus.b     = 8'($urandom);
            bus.bin   = ~v.bin;
            check($sformatf("v%0d_run_busy", i), 32'(bus.busy), 32'd1);
            check($sformatf("v%0d_run_hold", i), 32'(bus.diff), 32'(prev_diff));
            wait_done($sformatf("v%0d", i), cyc);
            check_result($sformatf("v%0d", i), v);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), 32'(bus.done), 32'd0);
            prev_diff = v.diff;
        end

        // Back-to-back: a new start presented in the DONE cycle is accepted.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h5A; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_first", cyc);
        check_result("b2b_first", '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'h00; bus.bin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 8'hAA; bus.b = 8'h55; bus.bin = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_low", 32'(bus.done), 32'd0);
        check("b2b_hold_zero", 32'(bus.zero), 32'd1);
        wait_done("b2b_second", cyc);
        check_result("b2b_second", '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0});

        // A start while busy is ignored and produces no extra done pulse.
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h35; bus.b = 8'h12; bus.bin = 1'b0;
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'h00; bus.bin = 1'b1;
        pulses = 0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done) begin
                pulses++;
                check("ign_diff", 32'(bus.diff), 32'h23);
                check("ign_bout", 32'(bus.bout), 32'd0);
            end
            @(negedge clk);
        end
        check("ign_pulses", 32'(pulses), 32'd1);

        // Reset during RUN discards the operation.
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h35; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_diff", 32'(bus.diff), 32'd0);
        check("mid_rst_bout", 32'(bus.bout), 32'd0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("mid_rst_no_done", 32'(pulses), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
